// File: rtl/lut_stream_writer.sv
// RAM-backed lookup table reprogrammed from a framed byte stream (addr, len-1, data...).
// Synchronous read port with one cycle of latency, read-first on a same-address write.
module lut_stream_writer #(
  parameter int LUT_ADDR_WIDTH = 8,
  parameter int LUT_DATA_WIDTH = 8
) (
  input  logic                      in_clk,
  input  logic                      in_rst_n,
  input  logic [7:0]                in_byte,
  input  logic                      in_byte_valid,
  output logic                      out_byte_ready,
  input  logic                      in_abort,
  input  logic [LUT_ADDR_WIDTH-1:0] in_rd_addr,
  output logic [LUT_DATA_WIDTH-1:0] out_rd_data,
  output logic                      out_busy,
  output logic                      out_done,
  output logic                      out_err,
  output logic [8:0]                out_wr_count
);

  localparam int DEPTH = 2 ** LUT_ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_ADDR = 2'd0,
    S_LEN  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [LUT_ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]                  remaining_q, remaining_d;
  logic [8:0]                  wr_count_q, wr_count_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic [LUT_DATA_WIDTH-1:0]   rd_data_q;
  logic                        wr_en;
  logic                        xfer;

  logic [LUT_DATA_WIDTH-1:0]   mem [DEPTH];

  assign out_byte_ready = (state_q != S_DONE);
  assign xfer           = in_byte_valid & out_byte_ready;

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    remaining_d = remaining_q;
    wr_count_d  = wr_count_q;
    err_d       = 1'b0;
    wr_en       = 1'b0;
    // Abort wins over any byte presented in the same cycle.
    if (in_abort) begin
      state_d = S_ADDR;
      err_d   = (state_q == S_LEN) || (state_q == S_DATA);
    end else begin
      case (state_q)
        S_ADDR: if (xfer) begin
          wr_addr_d  = in_byte[LUT_ADDR_WIDTH-1:0];
          wr_count_d = 9'd0;
          state_d    = S_LEN;
        end
        S_LEN: if (xfer) begin
          remaining_d = in_byte;
          state_d     = S_DATA;
        end
        S_DATA: if (xfer) begin
          wr_en      = 1'b1;
          wr_addr_d  = wr_addr_q + LUT_ADDR_WIDTH'(1);
          wr_count_d = wr_count_q + 9'd1;
          if (remaining_q == 8'd0) state_d = S_DONE;
          else                     remaining_d = remaining_q - 8'd1;
        end
        S_DONE: state_d = S_ADDR;
        default: state_d = S_ADDR;
      endcase
    end
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q     <= S_ADDR;
      wr_addr_q   <= '0;
      remaining_q <= 8'd0;
      wr_count_q  <= 9'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      remaining_q <= remaining_d;
      wr_count_q  <= wr_count_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Array carries no reset so it maps onto a simple dual-port block RAM.
  always_ff @(posedge in_clk) begin
    if (wr_en) mem[wr_addr_q] <= LUT_DATA_WIDTH'(in_byte);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) rd_data_q <= '0;
    else           rd_data_q <= mem[in_rd_addr];
  end

  assign out_rd_data  = rd_data_q;
  assign out_busy     = (state_q != S_ADDR);
  assign out_done     = done_q;
  assign out_err      = err_q;
  assign out_wr_count = wr_count_q;

endmodule

// File: tb/tb_lut_stream_writer.sv
// Directed bench for lut_stream_writer: framing, wrap, read-first collision,
// abort, gapped full-length frame and asynchronous reset mid-frame.
module tb_lut_stream_writer;

  logic       in_clk = 1'b0;
  logic       in_rst_n;
  logic [7:0] in_byte;
  logic       in_byte_valid;
  logic       out_byte_ready;
  logic       in_abort;
  logic [7:0] in_rd_addr;
  logic [7:0] out_rd_data;
  logic       out_busy;
  logic       out_done;
  logic       out_err;
  logic [8:0] out_wr_count;

  int vectors = 0;
  int miscompares = 0;

  lut_stream_writer #(.LUT_ADDR_WIDTH(8), .LUT_DATA_WIDTH(8)) dut (
    .in_clk        (in_clk),
    .in_rst_n      (in_rst_n),
    .in_byte       (in_byte),
    .in_byte_valid (in_byte_valid),
    .out_byte_ready(out_byte_ready),
    .in_abort      (in_abort),
    .in_rd_addr    (in_rd_addr),
    .out_rd_data   (out_rd_data),
    .out_busy      (out_busy),
    .out_done      (out_done),
    .out_err       (out_err),
    .out_wr_count  (out_wr_count)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  // Present one byte, optionally preceded by random idle cycles, until accepted.
  task automatic send(input logic [7:0] b, input bit gaps);
    bit sent = 1'b0;
    if (gaps) begin
      int idle = $urandom_range(0, 1);
      in_byte_valid = 1'b0;
      for (int k = 0; k < idle; k++) tick();
    end
    in_byte = b;
    in_byte_valid = 1'b1;
    for (int k = 0; k < 10 && !sent; k++) begin
      if (out_byte_ready) sent = 1'b1;
      tick();
    end
    in_byte_valid = 1'b0;
    if (!sent) begin
      vectors++;
      miscompares++;
      $error("FAIL send_timeout observed=ready_low expected=ready_high");
    end
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    in_rd_addr = a;
    tick();
    chk(tag, 32'(out_rd_data), 32'(exp));
  endtask

  // Leave S_DONE back to S_ADDR.
  task automatic finish_frame(input string tag);
    chk({tag, "_done"}, 32'(out_done), 32'd1);
    chk({tag, "_ready_low"}, 32'(out_byte_ready), 32'd0);
    tick();
    chk({tag, "_done_clr"}, 32'(out_done), 32'd0);
  endtask

  initial begin
    in_rst_n = 1'b0;
    in_byte = 8'h00;
    in_byte_valid = 1'b0;
    in_abort = 1'b0;
    in_rd_addr = 8'h00;
    #2;
    chk("rst_busy", 32'(out_busy), 32'd0);
    chk("rst_done", 32'(out_done), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_cnt", 32'(out_wr_count), 32'd0);
    chk("rst_ready", 32'(out_byte_ready), 32'd1);
    chk("rst_rd", 32'(out_rd_data), 32'd0);
    tick(); tick();
    in_rst_n = 1'b1;
    tick();

    // Basic frame, with a hold in S_LEN
    send(8'h10, 1'b0);
    chk("t1_busy", 32'(out_busy), 32'd1);
    for (int k = 0; k < 4; k++) tick();
    chk("t1_hold_busy", 32'(out_busy), 32'd1);
    chk("t1_hold_cnt", 32'(out_wr_count), 32'd0);
    send(8'h02, 1'b0);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    chk("t1_cnt", 32'(out_wr_count), 32'd3);
    finish_frame("t1");
    chk("t1_ready_back", 32'(out_byte_ready), 32'd1);
    chk("t1_idle", 32'(out_busy), 32'd0);
    rd_chk("t1_m10", 8'h10, 8'hAA);
    rd_chk("t1_m11", 8'h11, 8'hBB);
    rd_chk("t1_m12", 8'h12, 8'hCC);

    // Address wrap
    send(8'hFE, 1'b0); send(8'h03, 1'b0);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    chk("t2_cnt", 32'(out_wr_count), 32'd4);
    finish_frame("t2");
    rd_chk("t2_mFE", 8'hFE, 8'h01);
    rd_chk("t2_mFF", 8'hFF, 8'h02);
    rd_chk("t2_m00", 8'h00, 8'h03);
    rd_chk("t2_m01", 8'h01, 8'h04);

    // Read-first collision
    send(8'h20, 1'b0); send(8'h00, 1'b0); send(8'h11, 1'b0);
    finish_frame("t3a");
    send(8'h20, 1'b0); send(8'h00, 1'b0);
    in_rd_addr = 8'h20;
    in_byte = 8'h55;
    in_byte_valid = 1'b1;
    tick();
    in_byte_valid = 1'b0;
    chk("t3_old", 32'(out_rd_data), 32'h11);
    finish_frame("t3b");
    chk("t3_new", 32'(out_rd_data), 32'h55);

    // Abort mid-data
    send(8'h42, 1'b0); send(8'h00, 1'b0); send(8'h3C, 1'b0);
    finish_frame("t4a");
    send(8'h40, 1'b0); send(8'h04, 1'b0); send(8'h09, 1'b0); send(8'h08, 1'b0);
    in_abort = 1'b1;
    in_byte = 8'hEE;
    in_byte_valid = 1'b1;
    tick();
    in_abort = 1'b0;
    in_byte_valid = 1'b0;
    chk("t4_err", 32'(out_err), 32'd1);
    chk("t4_idle", 32'(out_busy), 32'd0);
    chk("t4_cnt", 32'(out_wr_count), 32'd2);
    tick();
    chk("t4_err_clr", 32'(out_err), 32'd0);
    rd_chk("t4_m40", 8'h40, 8'h09);
    rd_chk("t4_m41", 8'h41, 8'h08);
    rd_chk("t4_m42", 8'h42, 8'h3C);
    in_abort = 1'b1;
    tick();
    in_abort = 1'b0;
    chk("t4_idle_abort_noerr", 32'(out_err), 32'd0);
    send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h77, 1'b0);
    finish_frame("t4b");
    rd_chk("t4_m00", 8'h00, 8'h77);

    // Full 256-entry frame with random gaps
    send(8'h00, 1'b1); send(8'hFF, 1'b1);
    for (int i = 0; i < 256; i++) send(8'(i) ^ 8'h5A, 1'b1);
    chk("t5_cnt", 32'(out_wr_count), 32'h100);
    finish_frame("t5");
    for (int i = 0; i < 256; i++) rd_chk($sformatf("t5_m%02h", i), 8'(i), 8'(i) ^ 8'h5A);

    // Asynchronous reset mid-frame
    send(8'h80, 1'b0); send(8'h0F, 1'b0);
    send(8'hD1, 1'b0); send(8'hD2, 1'b0); send(8'hD3, 1'b0);
    in_rd_addr = 8'h80;
    tick();
    chk("t5_pre_rd", 32'(out_rd_data), 32'hD1);
    #2;
    in_rst_n = 1'b0;
    #1;
    chk("t5_arst_busy", 32'(out_busy), 32'd0);
    chk("t5_arst_cnt", 32'(out_wr_count), 32'd0);
    chk("t5_arst_rd", 32'(out_rd_data), 32'd0);
    chk("t5_arst_ready", 32'(out_byte_ready), 32'd1);
    chk("t5_arst_done", 32'(out_done), 32'd0);
    tick();
    in_rst_n = 1'b1;
    tick();
    send(8'h90, 1'b0); send(8'h00, 1'b0); send(8'h66, 1'b0);
    chk("t5_new_cnt", 32'(out_wr_count), 32'd1);
    finish_frame("t5b");
    rd_chk("t5_m90", 8'h90, 8'h66);
    rd_chk("t5_m82", 8'h82, 8'hD3);
    rd_chk("t5_m83", 8'h83, 8'h5A ^ 8'h83);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
